muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Sequences the iterative mult and div units on behalf of the main control unit. Accepts a one-cycle start request and pulses the selected unit's init line. It then waits for that unit's stop, and loads HI/LO through their source muxes. It raises a divide-by-zero or timeout exception instead of writing HI/LO, and holds busy so the control unit stalls during the operation.

Parameters:
TIMEOUT_CYCLES, 40, max RUN-state cycles before the operation is aborted as a timeout
CNT_W, 6, width of the internal cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start_mult  input  1  one-cycle request from control unit: run mult on A/B
start_div  input  1  one-cycle request from control unit: run div on A/B
divisor_zero  input  1  B_Out == 0, sampled with start_div
mult_stop  input  1  mult unit finished, results valid on its HI/LO outputs
div_stop  input  1  div unit finished
div_zero  input  1  div unit's own zero-divisor flag, checked while running
flush  input  1  synchronous abort from control unit
mult_init  output  1  one-cycle pulse to mult unit
div_init  output  1  one-cycle pulse to div unit
hilo_sel  output  1  HI/LO mux select: 0 = mult results, 1 = div results
high_load  output  1  load enable for HI register
low_load  output  1  load enable for LO register
busy  output  1  operation in progress; control unit stalls
done  output  1  one-cycle pulse: HI/LO updated
div_zero_exc  output  1  one-cycle pulse: divide-by-zero exception
timeout_err  output  1  one-cycle pulse: unit failed to stop in time
cycle_count  output  CNT_W  RUN-state cycle counter (debug)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset is low: state IDLE, all outputs 0, cycle_count 0, hilo_sel 0.
- Output timing: all outputs are registered and decoded from the state entered.
- States: IDLE, MULT_RUN, DIV_RUN, WRITE_HL, DONE, EXC.
- IDLE, start_mult=1: go to MULT_RUN. Start mult has priority when start_mult and start_div are both 1; start_div is dropped.
- IDLE, start_div=1 and divisor_zero=1: go to EXC with div_zero_exc. div_init is never pulsed.
- IDLE, start_div=1 and divisor_zero=0: go to DIV_RUN.
- RUN entry: mult_init or div_init is 1 only in the first RUN cycle. hilo_sel is set on entry (0 for MULT_RUN, 1 for DIV_RUN) and held until IDLE. cycle_count is cleared on entry and increments once per RUN cycle.
- RUN exit, in priority order:
  - stop of the active unit sampled 1: go to WRITE_HL.
  - DIV_RUN only, div_zero=1: go to EXC with div_zero_exc.
  - cycle_count == TIMEOUT_CYCLES-1: go to EXC with timeout_err.
  - Stop wins over div_zero, and stop wins over timeout, when they occur in the same cycle.
- The inactive unit's stop is ignored.
- WRITE_HL: high_load=low_load=1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- EXC: div_zero_exc or timeout_err is 1 for one cycle (never both), high_load=low_load=0, then go to IDLE.
- busy: 1 in every non-IDLE state, 0 in IDLE.
- Start requests while busy=1 are ignored and not queued.
- Latency, with start sampled at edge t and stop sampled at edge s:
  - init high in cycle t+1.
  - high_load/low_load high in cycle s+1.
  - done high in cycle s+2.
  - busy falls at s+3.
- flush=1 in any state: go to IDLE next edge. All pulses are suppressed and no HI/LO load occurs. flush has priority over every other transition, including stop in the same cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The mult/div units are reset by the same line.
- cycle_count saturates at TIMEOUT_CYCLES-1, never wraps, and holds its last value in WRITE_HL/DONE/EXC/IDLE until the next RUN entry.

Test Plan:
- Reset and mult: reset low then high; start_mult at cycle 2, mult_stop at cycle 35 -> mult_init=1 in cycle 3 only, hilo_sel=0, high_load=low_load=1 in cycle 36, done=1 in cycle 37, busy=1 in cycles 3..37.
- Divide by zero at start: start_div=1 with divisor_zero=1 -> next cycle div_zero_exc=1, busy=1 for one cycle, div_init and high_load never 1.
- Timeout with TIMEOUT_CYCLES=40: start_div, div_stop never asserted -> div_init once, cycle_count reaches 39, then timeout_err=1 for one cycle, no HI/LO load, IDLE.
- Simultaneous events: start_mult=start_div=1 -> MULT_RUN with hilo_sel=0. In a later div run, div_stop and div_zero are both 1 in the same cycle -> WRITE_HL, no exception. A start_mult mid-run has no effect.
- Abort paths: flush=1 in the same cycle as mult_stop -> IDLE, no high_load, no done. Reset pulled low during DIV_RUN -> all outputs 0 asynchronously; after release, a fresh start_div works normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Drives the iterative mult/div units for the main control unit. A one-cycle
//   start request pulses the chosen unit's init line. The sequencer then waits
//   for that unit's stop and loads HI/LO through their source muxes. It raises
//   a divide-by-zero or timeout exception instead of loading HI/LO when the
//   operation cannot complete. busy stalls the control unit for the whole
//   operation.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low
//   start_mult     one-cycle request: run mult on A/B (wins over start_div)
//   start_div      one-cycle request: run div on A/B
//   divisor_zero   B == 0, sampled together with start_div
//   mult_stop      mult unit finished
//   div_stop       div unit finished
//   div_zero       div unit's own zero-divisor flag, checked while dividing
//   flush          synchronous abort, overrides everything
//   mult_init      one-cycle init pulse to the mult unit
//   div_init       one-cycle init pulse to the div unit
//   hilo_sel       HI/LO source select: 0 = mult, 1 = div
//   high_load      HI register load enable
//   low_load       LO register load enable
//   busy           operation in progress
//   done           one-cycle pulse: HI/LO were just updated
//   div_zero_exc   one-cycle pulse: divide-by-zero exception
//   timeout_err    one-cycle pulse: unit did not stop in time
//   cycle_count    RUN-state cycle counter (debug)

module muldiv_sequencer #(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic             divisor_zero,
   input  logic             mult_stop,
   input  logic             div_stop,
   input  logic             div_zero,
   input  logic             flush,
   output logic             mult_init,
   output logic             div_init,
   output logic             hilo_sel,
   output logic             high_load,
   output logic             low_load,
   output logic             busy,
   output logic             done,
   output logic             div_zero_exc,
   output logic             timeout_err,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT_RUN,
      S_DIV_RUN,
      S_WRITE_HL,
      S_DONE,
      S_EXC
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t state, state_nxt;

   // Exception cause travels with the transition into S_EXC so that the
   // registered pulse can tell the two causes apart.
   logic zexc_nxt;
   logic tout_nxt;

   logic at_limit;
   logic mult_entry;
   logic div_entry;

   assign at_limit   = (cycle_count == CNT_LIMIT);
   assign mult_entry = (state_nxt == S_MULT_RUN) && (state != S_MULT_RUN);
   assign div_entry  = (state_nxt == S_DIV_RUN)  && (state != S_DIV_RUN);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // Next-state logic. flush overrides every transition, including a
   // stop in the same cycle, so no pulse or HI/LO load leaks out.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      zexc_nxt  = 1'b0;
      tout_nxt  = 1'b0;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_mult) begin
                  state_nxt = S_MULT_RUN;
               end else if (start_div) begin
                  // A zero divisor is caught before the div unit is started.
                  if (divisor_zero) begin
                     state_nxt = S_EXC;
                     zexc_nxt  = 1'b1;
                  end else begin
                     state_nxt = S_DIV_RUN;
                  end
               end
            end
            S_MULT_RUN: begin
               if (mult_stop) begin
                  state_nxt = S_WRITE_HL;
               end else if (at_limit) begin
                  state_nxt = S_EXC;
                  tout_nxt  = 1'b1;
               end
            end
            S_DIV_RUN: begin
               // A finished result is kept even if the zero flag or the
               // timeout fires in the same cycle.
               if (div_stop) begin
                  state_nxt = S_WRITE_HL;
               end else if (div_zero) begin
                  state_nxt = S_EXC;
                  zexc_nxt  = 1'b1;
               end else if (at_limit) begin
                  state_nxt = S_EXC;
                  tout_nxt  = 1'b1;
               end
            end
            S_WRITE_HL: state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            S_EXC:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs, decoded from the state being entered so that
   // every output is glitch-free and aligned with the new state.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mult_init    <= 1'b0;
         div_init     <= 1'b0;
         hilo_sel     <= 1'b0;
         high_load    <= 1'b0;
         low_load     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         div_zero_exc <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         mult_init    <= mult_entry;
         div_init     <= div_entry;
         high_load    <= (state_nxt == S_WRITE_HL);
         low_load     <= (state_nxt == S_WRITE_HL);
         busy         <= (state_nxt != S_IDLE);
         done         <= (state_nxt == S_DONE);
         div_zero_exc <= zexc_nxt;
         timeout_err  <= tout_nxt;
         // The mux select is only changed on RUN entry and then held, so
         // HI/LO see a stable source through WRITE_HL.
         if (mult_entry)     hilo_sel <= 1'b0;
         else if (div_entry) hilo_sel <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // RUN cycle counter: cleared on entry, counts each RUN cycle, and
   // saturates at the timeout limit. Outside RUN it keeps its last value
   // for debug visibility.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
      end else if (mult_entry || div_entry) begin
         cycle_count <= '0;
      end else if ((state == S_MULT_RUN || state == S_DIV_RUN) && !at_limit) begin
         cycle_count <= cycle_count + 1'b1;
      end
   end

endmodule
